// File: rtl/alu_multicycle.sv
// alu_multicycle: execution-stage ALU for the pipelined RISC-V core.
// AND/XOR/SLL/ADD/SUB/ADDI/SRAI finish in one cycle. MUL is an iterative
// shift-add multiplier that runs under a valid/ready handshake.
// Optional macro ALU_MUL_EARLY_EXIT_EN: MUL stops as soon as the remaining
// multiplier bits are all zero. Without it, MUL always takes WIDTH busy cycles.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mplier_shr;
  logic [CNT_W-1:0] cnt_inc;
  logic             mul_done;
  logic [SH_W-1:0]  shamt;

  assign shamt = data2_i[SH_W-1:0];

  // Single-cycle result datapath; MUL is handled by the iterative path.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:           alu_res = data1_i & data2_i;
      OP_XOR:           alu_res = data1_i ^ data2_i;
      OP_SLL:           alu_res = data1_i << shamt;
      OP_ADD, OP_ADDI:  alu_res = data1_i + data2_i;
      OP_SUB:           alu_res = data1_i - data2_i;
      OP_SRAI:          alu_res = $signed(data1_i) >>> shamt;
      default:          alu_res = '0;
    endcase
  end

  // One shift-add step. The counter saturates so termination never sees a wrapped value.
  always_comb begin
    acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_shr = mplier_q >> 1;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    mul_done   = (cnt_inc == CNT_MAX) || (mplier_shr == '0);
`else
    mul_done   = (cnt_inc == CNT_MAX);
`endif
  end

  // Next-state and datapath update; result regs hold unless a result completes.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_BUSY;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        // valid_i is ignored here; the requester holds it until ready_o returns.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_inc;
        if (mul_done) begin
          data_d  = acc_step;
          zero_d  = (acc_step == '0);
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight MUL without a result pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: vector table plus hand-written handshake/reset
// sequences; results are checked through an expected-result queue.
module tb_alu_multicycle;

  logic        clk_i, rst_i, valid_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i;
  logic        ready_o, valid_o, zero_o;
  logic [31:0] data_o;

  alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .zero_o(zero_o)
  );

  localparam logic [2:0] AND_ = 3'b000, XOR_ = 3'b001, SLL_ = 3'b010, ADD_ = 3'b011;
  localparam logic [2:0] SUB_ = 3'b100, MUL_ = 3'b101, ADDI = 3'b110, SRAI = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic        expz;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic        z;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  vec_t vecs[15];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent reference model for randomized vectors.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      AND_:       return a & b;
      XOR_:       return a ^ b;
      SLL_:       return a << b[4:0];
      ADD_, ADDI: return a + b;
      SUB_:       return a - b;
      MUL_:       return a * b;
      default:    return $signed(a) >>> b[4:0];
    endcase
  endfunction

  // Negedges from the accept edge until valid_o is seen.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    int hi;
    hi = 0;
    if (op != MUL_) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return hi + 2;
`else
    return 33 + hi;
`endif
  endfunction

  // Result monitor: every valid_o pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i && valid_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_valid: valid_o=1 with nothing outstanding, data_o=%h", data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_o !== mon_e.d || zero_o !== mon_e.z) begin
          n_err++;
          $display("FAIL result: data_o=%h zero_o=%b, expected %h/%b", data_o, zero_o, mon_e.d, mon_e.z);
        end
      end
    end
  end

  // Drive a request and hold it until accepted; optionally queue its result.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input logic expz, input bit push);
    int   guard;
    res_t r;
    guard = 0;
    @(negedge clk_i);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    chk("accept_timeout", {31'd0, ready_o}, 32'd1);
    r.d = exp; r.z = expz;
    if (push) exp_q.push_back(r);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  // Wait for the result pulse, checking latency, ready_o behaviour and pulse width.
  task automatic wait_result(input string name, input int lat);
    int n, rdy_hi;
    n = 0; rdy_hi = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (!valid_o && ready_o) rdy_hi++;
    end while (!valid_o && n < 200);
    chk({name, "_latency"}, n, lat);
    if (lat > 1) chk({name, "_busy_ready_low"}, rdy_hi, 0);
    chk({name, "_ready_at_valid"}, {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    chk({name, "_pulse_end"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, spur;
    logic [2:0]  op;
    logic [31:0] a, b, e;
    res_t r;

    vecs[0]  = '{ADD_, 32'd7,          32'd5,          32'd12,         1'b0};
    vecs[1]  = '{SUB_, 32'd5,          32'd5,          32'd0,          1'b1};
    vecs[2]  = '{SRAI, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
    vecs[3]  = '{SLL_, 32'h0000_0001,  32'd31,         32'h8000_0000,  1'b0};
    vecs[4]  = '{AND_, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
    vecs[5]  = '{XOR_, 32'hFFFF_0000,  32'h0FF0_0FF0,  32'hF00F_0FF0,  1'b0};
    vecs[6]  = '{ADDI, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[7]  = '{SUB_, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[8]  = '{MUL_, 32'd3,          32'hFFFF_FFFE,  32'hFFFF_FFFA,  1'b0};
    vecs[9]  = '{MUL_, 32'd6,          32'd2,          32'd12,         1'b0};
    vecs[10] = '{MUL_, 32'd6,          32'd0,          32'd0,          1'b1};
    vecs[11] = '{MUL_, 32'd1,          32'h8000_0000,  32'h8000_0000,  1'b0};
    vecs[12] = '{SRAI, 32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF,  1'b0};
    vecs[13] = '{SLL_, 32'h1234_5678,  32'h24,         32'h2345_6780,  1'b0};
    vecs[14] = '{SRAI, 32'h8000_0000,  32'h21,         32'hC000_0000,  1'b0};

    rst_i = 1'b0; valid_i = 1'b0; ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_data",  data_o, 32'd0);
    chk("reset_zero",  {31'd0, zero_o}, 32'd0);
    rst_i = 1'b1;

    for (int i = 0; i < 15; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].expz, 1'b1);
      wait_result($sformatf("vec%0d", i), exp_lat(vecs[i].op, vecs[i].b));
    end

    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 0) ? 32'd0 : $urandom;
      e  = model(op, a, b);
      send(op, a, b, e, e == 32'd0, 1'b1);
      wait_result($sformatf("rnd%0d", i), exp_lat(op, b));
    end

    // ADD held through a MUL must be ignored, then taken in the MUL's valid cycle.
    send(MUL_, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0, 1'b1);
    valid_i = 1'b1; ALUCtrl_i = ADD_; data1_i = 32'd10; data2_i = 32'd20;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!valid_o && n < 200);
    chk("b2b_mul_latency", n, exp_lat(MUL_, 32'hFFFF_FFFE));
    chk("b2b_ready_in_valid_cycle", {31'd0, ready_o}, 32'd1);
    r.d = 32'd30; r.z = 1'b0;
    exp_q.push_back(r);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_add_valid", {31'd0, valid_o}, 32'd1);
    @(negedge clk_i);
    chk("b2b_add_single_pulse", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of a MUL: immediate clear, no late pulse.
    send(ADD_, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
    wait_result("pre_reset_add", 1);
    send(MUL_, 32'd5, 32'd7, 32'd35, 1'b0, 1'b0);
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_data",  data_o, 32'd0);
    chk("midrst_zero",  {31'd0, zero_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    spur = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) spur++;
    end
    chk("midrst_no_late_valid", spur, 0);
    send(ADD_, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
    wait_result("post_reset_add", 1);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execution-stage ALU for the pipelined RISC-V core. It consumes the 3-bit operation code produced by the ALU control decoder, together with two 32-bit operands. AND, XOR, SLL, ADD, SUB, ADDI and SRAI complete in one cycle. MUL runs as an iterative shift-add multiplier over several cycles under a valid/ready handshake, and the hazard logic stalls the pipeline on `ready_o`.

## Interface
- `WIDTH`, 32: operand and result width.
- `CNT_W`, 6: iteration counter width; must hold `WIDTH`.

- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset; asynchronous, active-low.
- `valid_i`  input  1  operation request.
- `ALUCtrl_i`  input  3  op code: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 ADDI, 111 SRAI.
- `data1_i`  input  WIDTH  operand A (rs1).
- `data2_i`  input  WIDTH  operand B: rs2, sign-extended immediate, or shift amount in [4:0].
- `ready_o`  output  1  block can accept a request this cycle.
- `valid_o`  output  1  one-cycle pulse; result is present.
- `data_o`  output  WIDTH  result, registered.
- `zero_o`  output  1  registered flag, set when the result is zero.

## Operation
- FSM states:
  - `IDLE`: `ready_o`=1.
  - `MUL_BUSY`: `ready_o`=0.
- A request is accepted when `valid_i` && `ready_o` at a rising edge.
- Single-cycle ops, accepted in `IDLE`:
  - At the accept edge, the block registers `data_o`, sets `zero_o`=(result==0) and sets `valid_o`=1.
  - The state stays `IDLE`.
- Result rules:
  - AND/XOR are bitwise.
  - ADD, ADDI and SUB wrap mod 2^32; no overflow flag.
  - SLL is `data1_i` << `data2_i[4:0]`.
  - SRAI is an arithmetic right shift of `data1_i` by `data2_i[4:0]`, sign-filled.
- MUL:
  - On accept, the block latches multiplicand=`data1_i` and multiplier=`data2_i`, clears the accumulator and counter, and enters `MUL_BUSY`.
  - Each `MUL_BUSY` cycle: if multiplier[0] is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After the terminating iteration, the block writes `data_o`=acc (low 32 bits of the product), updates `zero_o`, pulses `valid_o` and returns to `IDLE`.
  - The low 32 bits are identical for signed and unsigned operands.
- `valid_i` while `MUL_BUSY` is ignored and not latched; the requester must hold it.
- `data_o`/`zero_o` hold their last value between results.
- `valid_o` deasserts the cycle after its pulse.

## Timing
- Reset values: state `IDLE`, `ready_o`=1, `valid_o`=0, `data_o`=0, `zero_o`=0; accumulator, counter and operand registers are all 0.
- Reset asserted mid-MUL:
  - The block clears immediately to the reset values.
  - No `valid_o` pulse is ever produced for the aborted operation.
- Single-cycle op latency: `valid_o` is high in the cycle after the accept edge.
- MUL latency, without the macro: exactly `WIDTH` (32) `MUL_BUSY` cycles.
  - `valid_o` is high in the cycle after the 32nd busy edge.
  - Accept at edge k gives `valid_o`/`data_o` visible after edge k+32.
- `ready_o` is 0 from the cycle after a MUL accept through the cycle of the final iteration edge.
- `ready_o` is 1 in the `valid_o` cycle, so a back-to-back request is accepted on the same edge that clears `valid_o`.
- Counter wrap: the counter saturates at `WIDTH`; termination is compared against `WIDTH`, never an overflowed value.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN` defined:
  - MUL terminates after the first iteration whose post-shift multiplier is zero.
  - Latency is (index of the highest set bit of `data2_i`)+1 busy cycles.
  - Multiplier 0 finishes in 1 busy cycle.
- `ALU_MUL_EARLY_EXIT_EN` undefined:
  - Fixed 32-cycle MUL; the termination test is the counter only.
- Results are identical in both builds; only latency differs.

## Test plan
- ADD 7+5, then SUB 5-5:
  - ADD: `valid_o` one cycle after accept, `data_o`=12, `zero_o`=0.
  - SUB: `data_o`=0, `zero_o`=1.
- Shifts:
  - SRAI 0x80000000 by 4 → 0xF8000000.
  - SLL 0x00000001 by 31 → 0x80000000.
  - AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000.
- MUL 3 × 0xFFFFFFFE, macro off:
  - `ready_o`=0 for cycles 1–32 after accept.
  - `valid_o` pulse once, 32 edges after accept; `data_o`=0xFFFFFFFA.
- Handshake:
  - ADD request held during `MUL_BUSY` is ignored.
  - The same ADD is accepted in the MUL `valid_o` cycle; it yields its `valid_o` one cycle later, with no lost or duplicated pulse.
- Reset mid-MUL:
  - Drop `rst_i` at busy cycle 10 (asynchronously, mid-cycle). All outputs go to reset values at once and `ready_o`=1.
  - No `valid_o` ever appears afterwards, and a new ADD 1+1 works → 2.
- Macro on:
  - MUL 6×2 → `valid_o` after 2 busy cycles, `data_o`=12.
  - MUL 6×0 → 1 cycle, `data_o`=0, `zero_o`=1.
  - MUL 1×0x80000000 → 32 cycles.
